// File: rtl/spi_reg_bank.sv
// SPI target exposing NUM_CFG read/write config registers and NUM_STATUS read-only status registers.
// Optional build macro SPI_REG_BANK_MISO_OE_EN adds spi_miso_oe and holds spi_miso while idle.
module spi_reg_bank #(
  parameter int               NUM_CFG    = 8,
  parameter int               NUM_STATUS = 8,
  parameter int               WIDTH      = 8,
  parameter logic [WIDTH-1:0] CFG_RESET  = '0
) (
  input  logic                          clk,
  input  logic                          rstb,
  input  logic                          ena,
  input  logic [1:0]                    spi_mode,
  input  logic                          spi_cs_n,
  input  logic                          spi_clk,
  input  logic                          spi_mosi,
  output logic                          spi_miso,
`ifdef SPI_REG_BANK_MISO_OE_EN
  output logic                          spi_miso_oe,
`endif
  output logic [NUM_CFG*WIDTH-1:0]      config_regs,
  input  logic [NUM_STATUS*WIDTH-1:0]   status_regs,
  output logic [NUM_CFG-1:0]            cfg_wr,
  output logic                          busy
);

  localparam int TOTAL = NUM_CFG + NUM_STATUS;
  localparam int SR_W  = (WIDTH > 8) ? WIDTH : 8;

  typedef enum logic [1:0] {IDLE, CMD, DATA} state_t;

  logic cs_meta, cs_sync;
  logic sclk_meta, sclk_sync, sclk_d;
  logic mosi_meta, mosi_sync;

  // NOTE: every flop below uses non-blocking assignment so all registers update from pre-edge values.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      cs_meta   <= 1'b1;
      cs_sync   <= 1'b1;
      sclk_meta <= 1'b0;
      sclk_sync <= 1'b0;
      sclk_d    <= 1'b0;
      mosi_meta <= 1'b0;
      mosi_sync <= 1'b0;
    end else if (ena) begin
      cs_meta   <= spi_cs_n;
      cs_sync   <= cs_meta;
      sclk_meta <= spi_clk;
      sclk_sync <= sclk_meta;
      sclk_d    <= sclk_sync;
      mosi_meta <= spi_mosi;
      mosi_sync <= mosi_meta;
    end
  end

  state_t             state;
  logic [1:0]         mode_q;
  logic [6:0]         addr;
  logic               rw;
  logic [5:0]         bit_cnt;
  logic [SR_W-2:0]    rx_sr;
  logic [WIDTH-1:0]   tx_sr;
  logic [WIDTH-1:0]   wr_data;
  logic               cmd_done;
  logic               word_done;
  logic               miso_q;
  logic [NUM_CFG*WIDTH-1:0] cfg_q;

  logic            sclk_rise, sclk_fall, lead_edge, trail_edge;
  logic            sample_edge, shift_edge;
  logic [SR_W-1:0] rx_next;
  logic [6:0]      addr_next;
  logic [6:0]      rd_addr;
  logic [WIDTH-1:0] rd_data;

  // Leading edge leaves the CPOL idle level; CPHA picks which edge samples.
  assign sclk_rise   = sclk_sync & ~sclk_d;
  assign sclk_fall   = ~sclk_sync & sclk_d;
  assign lead_edge   = mode_q[1] ? sclk_fall : sclk_rise;
  assign trail_edge  = mode_q[1] ? sclk_rise : sclk_fall;
  assign sample_edge = mode_q[0] ? trail_edge : lead_edge;
  assign shift_edge  = mode_q[0] ? lead_edge : trail_edge;

  assign rx_next   = {rx_sr, mosi_sync};
  assign addr_next = (addr == 7'(TOTAL - 1)) ? 7'd0 : addr + 7'd1;
  assign rd_addr   = word_done ? addr_next : addr;

  // NOTE: rd_data gets a default before the loops so no latch is inferred for unmatched addresses.
  always_comb begin
    rd_data = '0;
    for (int i = 0; i < NUM_CFG; i++)
      if (rd_addr == 7'(i)) rd_data = cfg_q[i*WIDTH +: WIDTH];
    for (int i = 0; i < NUM_STATUS; i++)
      if (rd_addr == 7'(NUM_CFG + i)) rd_data = status_regs[i*WIDTH +: WIDTH];
  end

  // NOTE: the config bank is real state visible on config_regs, so it is reset like any control flop.
  always_ff @(posedge clk) begin
    if (!rstb) begin
      state     <= IDLE;
      mode_q    <= 2'b00;
      addr      <= '0;
      rw        <= 1'b0;
      bit_cnt   <= '0;
      rx_sr     <= '0;
      tx_sr     <= '0;
      wr_data   <= '0;
      cmd_done  <= 1'b0;
      word_done <= 1'b0;
      miso_q    <= 1'b0;
      cfg_wr    <= '0;
      cfg_q     <= {NUM_CFG{CFG_RESET}};
    end else if (ena) begin
      cfg_wr    <= '0;
      cmd_done  <= 1'b0;
      word_done <= 1'b0;
      if (cs_sync) begin
        // Mode tracks the pins while deselected and freezes once CS falls.
        state   <= IDLE;
        bit_cnt <= '0;
        mode_q  <= spi_mode;
`ifndef SPI_REG_BANK_MISO_OE_EN
        miso_q  <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state   <= CMD;
            bit_cnt <= '0;
            tx_sr   <= '0;
          end
          CMD, DATA: begin
            if (shift_edge) begin
              miso_q <= tx_sr[WIDTH-1];
              tx_sr  <= tx_sr << 1;
            end
            if (sample_edge) begin
              rx_sr <= rx_next[SR_W-2:0];
              if (state == CMD && bit_cnt == 6'd7) begin
                rw       <= rx_next[7];
                addr     <= rx_next[6:0];
                bit_cnt  <= '0;
                cmd_done <= 1'b1;
                state    <= DATA;
              end else if (state == DATA && bit_cnt == 6'(WIDTH - 1)) begin
                wr_data   <= rx_next[WIDTH-1:0];
                bit_cnt   <= '0;
                word_done <= 1'b1;
              end else begin
                bit_cnt <= bit_cnt + 6'd1;
              end
            end
          end
          default: state <= IDLE;
        endcase
      end

      // Word completion is acted on one clk after the sample: commit, advance, reload.
      if (cmd_done) tx_sr <= rd_data;
      if (word_done) begin
        if (rw) begin
          for (int i = 0; i < NUM_CFG; i++) begin
            if (addr == 7'(i)) begin
              cfg_q[i*WIDTH +: WIDTH] <= wr_data;
              cfg_wr[i]               <= 1'b1;
            end
          end
        end
        addr  <= addr_next;
        tx_sr <= rd_data;
      end
    end
  end

  assign config_regs = cfg_q;
  assign busy        = ~cs_sync;

`ifdef SPI_REG_BANK_MISO_OE_EN
  assign spi_miso    = miso_q;
  assign spi_miso_oe = ~cs_sync;
`else
  assign spi_miso    = miso_q & ~cs_sync;
`endif

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: bit-level SPI master plus a read-data scoreboard.
module tb_spi_reg_bank;

  localparam int HALF = 80;

  logic        clk = 1'b0;
  logic        rstb;
  logic        ena;
  logic [1:0]  spi_mode;
  logic        spi_cs_n;
  logic        spi_clk;
  logic        spi_mosi;
  logic        spi_miso;
  logic [63:0] config_regs;
  logic [63:0] status_regs;
  logic [7:0]  cfg_wr;
  logic        busy;

  int checks   = 0;
  int failures = 0;
  int wr_cnt [8];
  int exp_wr [8];
  logic [7:0] exp_cfg [8];
  logic [7:0] exp_q [$];
  logic [7:0] tx_bytes [8];
  int flip_at = -1;

  spi_reg_bank #(
    .NUM_CFG(8), .NUM_STATUS(8), .WIDTH(8), .CFG_RESET(8'hA5)
  ) dut (
    .clk(clk), .rstb(rstb), .ena(ena), .spi_mode(spi_mode),
    .spi_cs_n(spi_cs_n), .spi_clk(spi_clk), .spi_mosi(spi_mosi),
    .spi_miso(spi_miso), .config_regs(config_regs),
    .status_regs(status_regs), .cfg_wr(cfg_wr), .busy(busy)
  );

  always #5 clk = ~clk;

  always @(negedge clk)
    for (int i = 0; i < 8; i++) if (cfg_wr[i]) wr_cnt[i]++;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  // Bit-level master: tx[nbits-1] goes first; CS is released after the last bit.
  task automatic spi_frame(input logic [1:0] mode, input logic [63:0] tx, input int nbits,
                           output logic [63:0] rx);
    logic cpol, cpha;
    cpol = mode[1];
    cpha = mode[0];
    rx = '0;
    spi_mode = mode;
    spi_clk  = cpol;
    repeat (4) @(posedge clk);
    #2;
    spi_mosi = cpha ? 1'b0 : tx[nbits-1];
    spi_cs_n = 1'b0;
    #(HALF);
    check("busy_active", 32'(busy), 32'd1);
    for (int i = nbits - 1; i >= 0; i--) begin
      if (i == flip_at) spi_mode = spi_mode ^ 2'b01;
      if (!cpha) rx[i] = spi_miso;
      spi_clk = ~cpol;
      if (cpha) spi_mosi = tx[i];
      #(HALF);
      if (cpha) rx[i] = spi_miso;
      spi_clk = cpol;
      if (!cpha && i > 0) spi_mosi = tx[i-1];
      #(HALF);
    end
    spi_cs_n = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    check("busy_drop_3clk", 32'(busy), 32'd0);
    check("miso_idle", 32'(spi_miso), 32'd0);
    repeat (3) @(posedge clk);
  endtask

  // Sends tx_bytes[0] as command plus nwords data bytes and scores every returned word.
  task automatic do_frame(input logic [1:0] mode, input int nwords);
    logic [63:0] tx, rx;
    int nbits;
    tx = '0;
    for (int k = 0; k <= nwords; k++) tx = (tx << 8) | 64'(tx_bytes[k]);
    nbits = 8 + 8 * nwords;
    spi_frame(mode, tx, nbits, rx);
    for (int k = 0; k < nwords; k++) begin
      if (exp_q.size() == 0) check("sb_underflow", 32'd1, 32'd0);
      else check($sformatf("rd_word%0d", k), 32'(rx[(nwords-1-k)*8 +: 8]), 32'(exp_q.pop_front()));
    end
  endtask

  task automatic check_bank(input string tag);
    for (int i = 0; i < 8; i++) begin
      check($sformatf("%s_cfg%0d", tag, i), 32'(config_regs[i*8 +: 8]), 32'(exp_cfg[i]));
      check($sformatf("%s_wr%0d", tag, i), 32'(wr_cnt[i]), 32'(exp_wr[i]));
    end
  endtask

  initial begin
    logic [63:0] rx;
    for (int i = 0; i < 8; i++) begin
      wr_cnt[i] = 0;
      exp_wr[i] = 0;
      exp_cfg[i] = 8'hA5;
    end
    for (int i = 0; i < 8; i++) status_regs[i*8 +: 8] = 8'h50 + 8'(i);
    status_regs[63:56] = 8'h5A;
    rstb = 1'b0; ena = 1'b1; spi_mode = 2'b00;
    spi_cs_n = 1'b1; spi_clk = 1'b0; spi_mosi = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check("rst_cfg", config_regs[31:0], 32'hA5A5A5A5);
    check("rst_cfg_hi", config_regs[63:32], 32'hA5A5A5A5);
    check("rst_cfg_wr", 32'(cfg_wr), 32'd0);
    check("rst_miso", 32'(spi_miso), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    rstb = 1'b1;
    repeat (3) @(posedge clk);

    // Mode 0 write to cfg3 (old contents returned), then read it back.
    tx_bytes[0] = 8'h83; tx_bytes[1] = 8'h3C;
    exp_q.push_back(8'hA5);
    do_frame(2'b00, 1);
    exp_cfg[3] = 8'h3C; exp_wr[3] = 1;
    check_bank("m0_write");
    tx_bytes[0] = 8'h03; tx_bytes[1] = 8'h00;
    exp_q.push_back(8'h3C);
    do_frame(2'b00, 1);

    // Mode 3 burst: cfg6, cfg7, then status address 8 which ignores the write.
    tx_bytes[0] = 8'h86; tx_bytes[1] = 8'h11; tx_bytes[2] = 8'h22; tx_bytes[3] = 8'h33;
    exp_q.push_back(8'hA5); exp_q.push_back(8'hA5); exp_q.push_back(8'h50);
    do_frame(2'b11, 3);
    exp_cfg[6] = 8'h11; exp_cfg[7] = 8'h22; exp_wr[6] = 1; exp_wr[7] = 1;
    check_bank("m3_burst");

    // Wrap from the last status register back to cfg0, in mode 1.
    tx_bytes[0] = 8'h0F; tx_bytes[1] = 8'h00; tx_bytes[2] = 8'h00;
    exp_q.push_back(8'h5A); exp_q.push_back(8'hA5);
    do_frame(2'b01, 2);

    // Out-of-range read returns zero, in mode 2.
    tx_bytes[0] = 8'h14; tx_bytes[1] = 8'h00;
    exp_q.push_back(8'h00);
    do_frame(2'b10, 1);

    // Abort after 5 data bits: nothing committed.
    spi_frame(2'b00, (64'h82 << 5) | 64'h15, 13, rx);
    check_bank("abort");

    // spi_mode flips mid-frame; mode 0 remains in force.
    tx_bytes[0] = 8'h81; tx_bytes[1] = 8'h77;
    exp_q.push_back(8'hA5);
    flip_at = 4;
    do_frame(2'b00, 1);
    flip_at = -1;
    exp_cfg[1] = 8'h77; exp_wr[1] = 1;
    check_bank("mode_flip");
    tx_bytes[0] = 8'h01; tx_bytes[1] = 8'h00;
    exp_q.push_back(8'h77);
    do_frame(2'b00, 1);

    check("sb_drained", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/spi_reg_bank.md
Name: spi_reg_bank

Overview:
- Parametrised SPI target giving an external host read/write access to a bank of configuration registers and read-only access to status registers.
- Successor to the fixed 8x8 SPI wrapper. Adds:
  - run-time SPI mode (CPOL/CPHA);
  - burst transfers with address auto-increment and wrap-around;
  - split config/status address map;
  - per-register write strobes.
- Instantiated directly from the tt_um top. Raw ui_in pins connect straight to the SPI inputs; synchronisers are internal.

Parameters:
- NUM_CFG, 8, number of read/write config registers; addresses 0..NUM_CFG-1.
- NUM_STATUS, 8, number of read-only status registers; addresses NUM_CFG..NUM_CFG+NUM_STATUS-1.
- WIDTH, 8, register width and bits per data word. Legal range 1..32.
- CFG_RESET, 0, reset value loaded into every config register.
- NUM_CFG+NUM_STATUS must be at most 128.

Ports:
- clk  in  1  system clock. Must run at 6x spi_clk or faster.
- rstb  in  1  reset: synchronous, active-low.
- ena  in  1  clock enable. When low, all state holds.
- spi_mode  in  2  [1]=CPOL, [0]=CPHA. Sampled only while spi_cs_n_sync is high.
- spi_cs_n  in  1  raw chip select, active-low, asynchronous.
- spi_clk  in  1  raw SPI clock, asynchronous.
- spi_mosi  in  1  raw serial data in, MSB first.
- spi_miso  out  1  serial data out, registered, MSB first.
- config_regs  out  NUM_CFG*WIDTH  flattened config registers; register i is at [i*WIDTH +: WIDTH].
- status_regs  in  NUM_STATUS*WIDTH  flattened status inputs, same packing.
- cfg_wr  out  NUM_CFG  one-clk pulse, bit i set when register i is written.
- busy  out  1  high while a transaction is active (spi_cs_n_sync low).

Behaviour:
- Input synchronisation:
  - spi_cs_n, spi_clk and spi_mosi each pass through a 2-flop synchroniser.
  - Synchronisers reset to 1, 0 and 0 respectively.
  - SCLK edges are detected on the synchronised signal against a third flop.
- Edge mapping:
  - leading edge = transition away from CPOL level; trailing edge = the other transition.
  - CPHA=0: sample on leading edge, shift on trailing edge. The first MISO bit is valid from CS fall.
  - CPHA=1: shift on leading edge, sample on trailing edge.
- Mode latching: mode is latched on the CS falling edge. Changes to spi_mode during a transaction are ignored.
- Frame format:
  - command byte: bit7 = R/W (1 = write), bits6:0 = start address.
  - followed by one or more WIDTH-bit data words, MSB first.
- FSM states:
  - IDLE: cs_n high.
    - Bit counter cleared, spi_miso = 0.
    - CS fall -> CMD.
  - CMD: shifts in 8 bits.
    - On the 8th sample: latch rw and addr.
    - For a read, load the shift register from addr on the next clk.
    - Then -> DATA.
  - DATA: shifts WIDTH bits.
    - On the WIDTH-th sample of a write: commit to config[addr] the following clk and pulse cfg_wr[addr] for 1 clk.
    - Then addr increments, wrapping from NUM_CFG+NUM_STATUS-1 to 0.
    - For a read, the shift register reloads from the new addr.
    - Stays in DATA for the next word.
  - Any state, CS rise -> IDLE within 3 clk.
    - A partial command or partial data word is discarded: no write, no strobe.
- Address map:
  - Writes to status or out-of-range addresses are ignored; no strobe is generated.
  - Reads of out-of-range addresses return 0.
  - Status read data is captured at word load time and is not re-sampled mid-word.
- MISO during write frames: spi_miso shifts out the previous contents of the addressed register. This gives read-before-write.
- Reset (rstb low at a clk edge):
  - config_regs = CFG_RESET; cfg_wr = 0; spi_miso = 0; busy = 0; FSM = IDLE.
  - Mid-transaction the frame is lost; the host must re-assert CS.
- ena low: all flops hold, including the synchronisers.
- Simultaneous CS rise and final sample in the same clk: CS rise wins and the word is discarded.

Optional Feature:
- Macro: SPI_REG_BANK_MISO_OE_EN.
- Defined:
  - adds output port spi_miso_oe (1 bit, reset 0);
  - spi_miso_oe is high exactly while busy is high;
  - spi_miso holds its last value when idle, for top-level tri-state/uio_oe use.
- Undefined:
  - the port is absent;
  - spi_miso is forced to 0 whenever cs_n_sync is high.

Test Plan:
- Reset config: rstb low 2 clk with CFG_RESET=8'hA5 -> all config_regs bytes read 8'hA5; cfg_wr=0; spi_miso=0.
- Mode 0 single write then read: write 8'h83, 8'h3C; then read 8'h03 -> config_regs[31:24]=8'h3C, cfg_wr[3] pulses once, read returns 8'h3C.
- Mode 3 burst write: command 8'h86 followed by 8'h11, 8'h22, 8'h33 (NUM_CFG=8, NUM_STATUS=8) -> cfg6=8'h11, cfg7=8'h22; 8'h33 goes to status address 8 and is ignored, with no strobe.
- Wrap read: status[7] (addr 15) = 8'h5A; command 8'h0F, 2 words -> returns 8'h5A then cfg0.
- Abort: write 8'h82 then only 5 data bits, then CS high -> cfg2 unchanged, no cfg_wr pulse, busy low within 3 clk.
- Mode change mid-frame: toggle spi_mode from 0 to 1 during a write to addr 1 under mode 0 -> transfer completes under mode 0 with correct data.
